// File: rtl/multicode_pkg.sv
// Shared types and glyph table for the multicode seven-segment display.
// All glyphs are active-low in {g,f,e,d,c,b,a} bit order.
package multicode_pkg;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_HEX = 2'd1,
        MODE_DEC = 2'd2,
        MODE_OCT = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_C     = 7'b1000110;
    localparam logic [6:0] GLYPH_D     = 7'b0100001;
    localparam logic [6:0] GLYPH_E     = 7'b0000110;
    localparam logic [6:0] GLYPH_F     = 7'b0001110;
    localparam logic [6:0] GLYPH_H     = 7'b0001011;
    localparam logic [6:0] GLYPH_LOW_D = 7'b0100001;
    localparam logic [6:0] GLYPH_LOW_O = 7'b0100011;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;

    // Map one 4-bit digit value to its 0-F glyph.
    function automatic logic [6:0] nibble_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronises one raw active-low button, debounces it and emits a
// single-cycle press pulse on each accepted 1->0 transition.
module button_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;
    logic          accept;

    // The level flips on the cycle the counter has seen DEBOUNCE differing cycles.
    assign accept = (sync_2 != level) && (cnt == CW'(DEBOUNCE - 1));
    // Only a released-to-pressed change is a press event.
    assign press  = accept && level;

    // Two-flop synchroniser; idle (released) level is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Stability counter: any reversion to the debounced level restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b1;
            cnt   <= '0;
        end else if (sync_2 == level) begin
            cnt <= '0;
        end else if (accept) begin
            level <= sync_2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicode_display.sv
// Shows a switch value in hex, decimal or octal on active-low seven-segment
// digits plus a mode letter. Decimal digits come from a sequential
// shift-add-3 converter; every displayed value passes through that converter
// so the mode letter and digits always change together on the DONE edge.
module multicode_display
    import multicode_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 3,
    parameter int DEBOUNCE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     switches,
    input  logic [2:0]            buttons,
    output logic [6:0]            mode_segments,
    output logic [7*DIGITS-1:0]   digit_segments,
    output logic                  busy,
    output logic [1:0]            fsm_state
);

    localparam int BCD_DIGITS = (DATA_W * 3) / 10 + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int OCT_DIGITS = (DATA_W + 2) / 3;
    localparam int NCAND_A    = (OCT_DIGITS > BCD_DIGITS) ? OCT_DIGITS : BCD_DIGITS;
    localparam int NCAND      = (NCAND_A > DIGITS) ? NCAND_A : DIGITS;
    localparam int CNT_W      = $clog2(DATA_W);

    logic [DATA_W-1:0]   sw_s1;
    logic [DATA_W-1:0]   sw_sync;
    logic                press_hex;
    logic                press_dec;
    logic                press_oct;
    mode_t               mode;

    conv_state_t         state;
    conv_state_t         state_next;
    logic                start;

    logic [DATA_W-1:0]   value;
    logic [DATA_W-1:0]   shreg;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic [BCD_W-1:0]    bcd_next;
    logic [CNT_W-1:0]    bit_cnt;
    mode_t               conv_mode;
    logic [DATA_W-1:0]   last_value;
    mode_t               last_mode;

    logic [4*NCAND-1:0]  val_ext;
    logic [4*NCAND-1:0]  bcd_ext;
    logic [3:0]          cand [NCAND];
    int                  msd;
    logic                overflow;
    logic [7*DIGITS-1:0] digits_next;
    logic [6:0]          mode_glyph;

    assign fsm_state = state;

    // Two-flop synchroniser for the asynchronous switch bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1   <= '0;
            sw_sync <= '0;
        end else begin
            sw_s1   <= switches;
            sw_sync <= sw_s1;
        end
    end

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_hex (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (buttons[2]),
        .press (press_hex)
    );

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_dec (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (buttons[1]),
        .press (press_dec)
    );

    button_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_oct (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (buttons[0]),
        .press (press_oct)
    );

    // Mode register: a press selects its mode, re-pressing the active mode blanks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= MODE_OFF;
        end else if (press_hex) begin
            mode <= (mode == MODE_HEX) ? MODE_OFF : MODE_HEX;
        end else if (press_dec) begin
            mode <= (mode == MODE_DEC) ? MODE_OFF : MODE_DEC;
        end else if (press_oct) begin
            mode <= (mode == MODE_OCT) ? MODE_OFF : MODE_OCT;
        end
    end

    // Converter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Converter next state: start only when something visible would change.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            CONV_IDLE: begin
                if ((mode != MODE_OFF) && ((sw_sync != last_value) || (mode != last_mode))) begin
                    state_next = CONV_SHIFT;
                    start      = 1'b1;
                end
            end
            CONV_SHIFT: begin
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    state_next = CONV_DONE;
                end
            end
            CONV_DONE: begin
                state_next = CONV_IDLE;
            end
            default: begin
                state_next = CONV_IDLE;
            end
        endcase
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift in the next MSB.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BCD_W-2:0], shreg[DATA_W-1]};
    end

    // Converter datapath; inputs are only sampled on the IDLE->SHIFT edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value      <= '0;
            shreg      <= '0;
            bcd        <= '0;
            bit_cnt    <= '0;
            busy       <= 1'b0;
            conv_mode  <= MODE_OFF;
            last_value <= '0;
            last_mode  <= MODE_OFF;
        end else begin
            case (state)
                CONV_IDLE: begin
                    if (start) begin
                        value     <= sw_sync;
                        shreg     <= sw_sync;
                        bcd       <= '0;
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        conv_mode <= mode;
                    end else if (mode == MODE_OFF) begin
                        // Forget the shown mode so leaving OFF always reconverts.
                        last_mode <= MODE_OFF;
                    end
                end
                CONV_SHIFT: begin
                    bcd     <= bcd_next;
                    shreg   <= {shreg[DATA_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                CONV_DONE: begin
                    busy       <= 1'b0;
                    last_value <= value;
                    last_mode  <= (mode == MODE_OFF) ? MODE_OFF : conv_mode;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    // Digit formation: pick per-base digit values, blank leading zeros, flag overflow.
    always_comb begin
        val_ext = '0;
        val_ext[DATA_W-1:0] = value;
        bcd_ext = '0;
        bcd_ext[BCD_W-1:0] = bcd;
        cand = '{default: 4'd0};
        for (int i = 0; i < NCAND; i++) begin
            case (conv_mode)
                MODE_HEX: cand[i] = val_ext[4*i +: 4];
                MODE_OCT: cand[i] = {1'b0, val_ext[3*i +: 3]};
                MODE_DEC: cand[i] = bcd_ext[4*i +: 4];
                default:  cand[i] = 4'd0;
            endcase
        end
        msd = 0;
        for (int i = 0; i < NCAND; i++) begin
            if (cand[i] != 4'd0) begin
                msd = i;
            end
        end
        overflow = (msd >= DIGITS);
        digits_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (overflow) begin
                digits_next[7*i +: 7] = GLYPH_DASH;
            end else if (i > msd) begin
                digits_next[7*i +: 7] = GLYPH_BLANK;
            end else begin
                digits_next[7*i +: 7] = nibble_glyph(cand[i]);
            end
        end
        case (conv_mode)
            MODE_HEX: mode_glyph = GLYPH_H;
            MODE_DEC: mode_glyph = GLYPH_LOW_D;
            MODE_OCT: mode_glyph = GLYPH_LOW_O;
            default:  mode_glyph = GLYPH_BLANK;
        endcase
    end

    // Output registers: blank while OFF, otherwise load together on DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_segments  <= GLYPH_BLANK;
            digit_segments <= '1;
        end else if (mode == MODE_OFF) begin
            mode_segments  <= GLYPH_BLANK;
            digit_segments <= '1;
        end else if (state == CONV_DONE) begin
            mode_segments  <= mode_glyph;
            digit_segments <= digits_next;
        end
    end

endmodule

// File: doc/multicode_display.md
# multicode_display

Parametrised multicode converter and display driver for the seven-segment board. It takes a DATA_W-bit switch value and shows it in hex, decimal or octal on DIGITS active-low digits, plus one mode-letter digit. The mode is latched from debounced button presses. Decimal digits come from a sequential shift-add-3 (double-dabble) converter. It sits between the board switch/button pins and the segment pins.

## Interface
- DATA_W, default 8: width of the switch value, 4..16.
- DIGITS, default 3: number of value digits. Must satisfy DIGITS >= ceil(DATA_W/4).
- DEBOUNCE, default 16: number of consecutive stable cycles required before a button change is accepted, >= 2.
- Clock  in  1: single clock, rising edge.
- Reset_n  in  1: asynchronous, active-low reset.
- Switches  in  DATA_W: raw binary input, asynchronous to Clock.
- Buttons  in  3: raw, active-low. [2]=HEX, [1]=DEC, [0]=OCT.
- ModeSegments  out  7: mode letter, active-low. h=0001011, d=0100001, o=0100011, blank=1111111.
- DigitSegments  out  7*DIGITS: value digits, active-low. [6:0] is the least significant digit.
- Busy  out  1: high while a conversion is in flight.

## Operation
- Synchronisation: Switches and Buttons each pass through a 2-flop synchroniser.
- Debounce, per button:
  - The debounced level changes only after the synchronised raw level has differed from it for DEBOUNCE consecutive cycles.
  - Any reversion before then resets that button's counter.
  - A press event is a debounced 1->0 transition.
- Mode register: OFF, HEX, DEC or OCT; reset value OFF.
  - A press event selects the corresponding mode.
  - A press event for the mode that is already active selects OFF (toggle blank).
  - Simultaneous press events resolve by priority HEX > DEC > OCT.
- Converter FSM, states IDLE, SHIFT, DONE:
  - IDLE -> SHIFT when the mode is not OFF and either the synchronised Switches differ from the last converted value or the mode changed since the last conversion. On this transition: capture the value, clear the BCD accumulator, clear the bit counter, set Busy=1.
  - SHIFT lasts exactly DATA_W cycles. Each cycle adds 3 to every BCD nibble >= 5, then shifts in the next MSB.
  - DONE: update the output registers, set Busy=0, return to IDLE.
  - Switch or mode changes during SHIFT are ignored. They are picked up in the next IDLE cycle, so the final displayed value always equals the final input.
- Digit formation:
  - HEX: digits are the 4-bit slices of the captured value.
  - OCT: digits are the 3-bit slices of the captured value.
  - DEC: digits are the BCD nibbles.
  - All digit glyphs use the standard 0-F glyph table.
- Leading-zero blanking: every digit above the most significant nonzero digit is blank. Digit 0 is always shown, so value 0 displays as "0".
- Overflow: if the value needs more than DIGITS digits in the active base, all value digits show dash (0111111).
- OFF mode: ModeSegments and all DigitSegments are blank. The FSM stays in IDLE. Entering OFF blanks the outputs on the next cycle.
- Reset is asynchronous: ModeSegments and DigitSegments all go to 1111111, Busy=0, the FSM goes to IDLE, the mode goes to OFF, and the debounce counters clear. Reset mid-conversion discards the conversion.

## Timing
- Switch change to synchronised value: 2 cycles.
- Button press to mode change: 2 + DEBOUNCE cycles.
- Start to output update: DATA_W+2 cycles. This covers the IDLE->SHIFT edge, DATA_W shift cycles and DONE.
- Busy is high for exactly DATA_W+1 cycles per conversion.
- ModeSegments and DigitSegments update together on the DONE edge. No intermediate values are ever visible.
- Entering OFF: outputs blank 1 cycle after the mode register changes.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package multicode_pkg:
  - mode enum (OFF/HEX/DEC/OCT);
  - glyph constants for 0-F, h, d, o, blank and dash;
  - a nibble-to-glyph function.
- Sub-module button_debounce, parametrised by DEBOUNCE. It contains the synchroniser, counter and press-event pulse, and is instantiated three times.
- The converter FSM and digit formation live in multicode_display.

## Test plan
- Reset:
  - Stimulus: Reset_n low with random inputs.
  - Required: all segment outputs 1111111 and Busy=0.
  - After release with no button press, outputs stay blank indefinitely.
- Decimal conversion, defaults:
  - Stimulus: press DEC, then Switches=173.
  - Required: ModeSegments=0100001; digits [2..0] = 1111001, 1111000, 0110000.
  - Required: update exactly 10 cycles after synchronisation, with Busy high for 9 cycles.
- Hex with blanking:
  - Stimulus: press HEX, Switches=8'h0A.
  - Required: ModeSegments=0001011; digit0=0001000; digits 1 and 2 blank.
  - Stimulus: Switches=0.
  - Required: digit0=1000000.
- Debounce and toggle:
  - Stimulus: a 10-cycle glitch on Buttons[1].
  - Required: no mode change.
  - Stimulus: two clean DEC presses.
  - Required: DEC is selected, then all outputs go blank.
  - Stimulus: HEX and OCT pressed in the same cycle.
  - Required: HEX is selected.
- Change mid-conversion:
  - Stimulus: Switches=5, changed to 200 during SHIFT cycle 3.
  - Required: the display shows 5, then Busy re-asserts, then the display shows 200.
- Overflow, with DIGITS=2:
  - Stimulus: DEC, Switches=100.
  - Required: both digits 0111111.
  - Stimulus: OCT, Switches=64.
  - Required: dashes.
  - Stimulus: OCT, Switches=63.
  - Required: display "77".
